// File: rtl/vc_fifo_bank.sv
// Virtual-channel input buffer: four independent first-word-fall-through FIFOs
// addressed by push_vc on the write side and by a per-VC pop mask on the read side.
module vc_fifo_bank #(
    parameter int DATA_W    = 4,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enb,
    input  logic              push,
    input  logic [1:0]        push_vc,
    input  logic [DATA_W-1:0] push_data,
    input  logic [3:0]        pop,
    output logic [DATA_W-1:0] vc_data0,
    output logic [DATA_W-1:0] vc_data1,
    output logic [DATA_W-1:0] vc_data2,
    output logic [DATA_W-1:0] vc_data3,
    output logic [3:0]        empty,
    output logic [3:0]        full,
    output logic [3:0]        almost_full,
    output logic [3:0]        almost_empty,
    output logic              overflow_err,
    output logic              underflow_err
);

    localparam int NUM_VC = 4;
    localparam int AW     = $clog2(DEPTH);
    localparam int PW     = AW + 1;

    logic [DATA_W-1:0] head [NUM_VC];
    logic [NUM_VC-1:0] ovf_hit;
    logic [NUM_VC-1:0] udf_hit;

    logic overflow_err_q, overflow_err_d;
    logic underflow_err_q, underflow_err_d;

    generate
        for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
            logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
            logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
            logic [PW-1:0]     count;
            logic [DATA_W-1:0] mem_q [DEPTH];
            logic              push_req, pop_req;
            logic              push_ok, pop_ok;
            logic              is_empty, is_full;

            assign count    = wr_ptr_q - rd_ptr_q;
            assign is_empty = (wr_ptr_q == rd_ptr_q);
            assign is_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

            // A pop on a full VC frees the slot the same-cycle push lands in.
            always_comb begin
                push_req = enb && push && (push_vc == 2'(gi));
                pop_req  = enb && pop[gi];
                pop_ok   = pop_req && !is_empty;
                push_ok  = push_req && (!is_full || pop_req);
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
            end

            assign ovf_hit[gi] = push_req && is_full && !pop_req;
            assign udf_hit[gi] = pop_req && is_empty;

            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                end
            end

            // Storage carries no reset; the pointers alone define validity.
            always_ff @(posedge clk) begin
                if (push_ok && !rst) begin
                    mem_q[wr_ptr_q[AW-1:0]] <= push_data;
                end
            end

            assign head[gi]         = is_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
            assign empty[gi]        = is_empty;
            assign full[gi]         = is_full;
            assign almost_full[gi]  = (count >= PW'(AF_THRESH));
            assign almost_empty[gi] = (count <= PW'(AE_THRESH));
        end
    endgenerate

    always_comb begin
        overflow_err_d  = overflow_err_q  || (|ovf_hit);
        underflow_err_d = underflow_err_q || (|udf_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err_q  <= 1'b0;
            underflow_err_q <= 1'b0;
        end else begin
            overflow_err_q  <= overflow_err_d;
            underflow_err_q <= underflow_err_d;
        end
    end

    assign vc_data0      = head[0];
    assign vc_data1      = head[1];
    assign vc_data2      = head[2];
    assign vc_data3      = head[3];
    assign overflow_err  = overflow_err_q;
    assign underflow_err = underflow_err_q;

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Bench for vc_fifo_bank: directed vector table for fill/drain, queue scoreboard
// for everything else, and hand sequences for overflow, full push+pop, hold and wrap.
module tb_vc_fifo_bank;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, enb, push;
    logic [1:0] push_vc;
    logic [3:0] push_data, pop;
    logic [3:0] d0, d1, d2, d3;
    logic [3:0] empty, full, almost_full, almost_empty;
    logic       overflow_err, underflow_err;
    logic [3:0] dout [4];

    always #5 clk = ~clk;

    vc_fifo_bank #(.DATA_W(4), .DEPTH(DEPTH), .AF_THRESH(3), .AE_THRESH(1)) dut (
        .clk(clk), .rst(rst), .enb(enb), .push(push), .push_vc(push_vc),
        .push_data(push_data), .pop(pop),
        .vc_data0(d0), .vc_data1(d1), .vc_data2(d2), .vc_data3(d3),
        .empty(empty), .full(full), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    assign dout[0] = d0;
    assign dout[1] = d1;
    assign dout[2] = d2;
    assign dout[3] = d3;

    int n_vec = 0;
    int n_bad = 0;

    logic [3:0] q [4][$];
    logic       ovf_m = 1'b0;
    logic       udf_m = 1'b0;

    typedef struct {
        logic       rst;
        logic       push;
        logic [1:0] vc;
        logic [3:0] data;
        logic [3:0] pop;
        logic [3:0] exp_empty;
        logic [3:0] exp_full;
        logic [3:0] exp_af;
        logic [3:0] exp_d2;
        logic       exp_udf;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all();
        logic [3:0] ee, ef, eaf, eae;
        for (int n = 0; n < 4; n++) begin
            ee[n]  = (q[n].size() == 0);
            ef[n]  = (q[n].size() == DEPTH);
            eaf[n] = (q[n].size() >= 3);
            eae[n] = (q[n].size() <= 1);
            chk($sformatf("vc_data%0d", n), 32'(dout[n]),
                32'((q[n].size() > 0) ? q[n][0] : 4'h0));
        end
        chk("empty", 32'(empty), 32'(ee));
        chk("full", 32'(full), 32'(ef));
        chk("almost_full", 32'(almost_full), 32'(eaf));
        chk("almost_empty", 32'(almost_empty), 32'(eae));
        chk("overflow_err", 32'(overflow_err), 32'(ovf_m));
        chk("underflow_err", 32'(underflow_err), 32'(udf_m));
    endtask

    // One clock: drive, compare popped heads against the scoreboard, clock, update model, check.
    task automatic step(input logic r, input logic e, input logic p, input logic [1:0] v,
                        input logic [3:0] d, input logic [3:0] pp);
        int sz [4];
        rst = r; enb = e; push = p; push_vc = v; push_data = d; pop = pp;
        #1;
        for (int n = 0; n < 4; n++) begin
            sz[n] = q[n].size();
            if (!r && e && pp[n] && sz[n] > 0)
                chk($sformatf("sb_pop_vc%0d", n), 32'(dout[n]), 32'(q[n][0]));
        end
        @(posedge clk);
        if (r) begin
            for (int n = 0; n < 4; n++) q[n].delete();
            ovf_m = 1'b0;
            udf_m = 1'b0;
        end else if (e) begin
            for (int n = 0; n < 4; n++) begin
                logic ph;
                ph = p && (v == 2'(n));
                if (pp[n] && sz[n] == 0) udf_m = 1'b1;
                if (ph && sz[n] == DEPTH && !pp[n]) ovf_m = 1'b1;
                if (pp[n] && sz[n] > 0) void'(q[n].pop_front());
                if (ph && (sz[n] < DEPTH || pp[n])) q[n].push_back(d);
            end
        end
        #1;
        check_all();
    endtask

    task automatic rand_traffic(input int cycles);
        for (int i = 0; i < cycles; i++)
            step(1'b0, 1'b1, 1'($urandom_range(1)), 2'($urandom_range(3)),
                 4'($urandom_range(15)), 4'($urandom_range(15)));
    endtask

    logic [3:0] s_empty, s_full, s_af, s_ae, s_d [4];
    logic       s_ovf, s_udf;

    initial begin
        // Fill then drain VC2 from reset; expectations written out by hand.
        tbl[0] = '{1'b1, 1'b0, 2'd0, 4'h0, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'h0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 2'd2, 4'h1, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'h1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 2'd2, 4'h2, 4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'h1, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 2'd2, 4'h3, 4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'h1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 2'd2, 4'h4, 4'b0000, 4'b1011, 4'b0100, 4'b0100, 4'h1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 4'b1011, 4'b0000, 4'b0100, 4'h2, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'h3, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 4'b1011, 4'b0000, 4'b0000, 4'h4, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'h0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 2'd0, 4'h0, 4'b0100, 4'b1111, 4'b0000, 4'b0000, 4'h0, 1'b1};

        rst = 1'b1; enb = 1'b0; push = 1'b0; push_vc = '0; push_data = '0; pop = '0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0, 2'd0, 4'h0, 4'h0);
        check_all();

        // Reset after random traffic, held two cycles.
        rand_traffic(30);
        step(1'b1, 1'b1, 1'b1, 2'd1, 4'h7, 4'hF);
        step(1'b1, 1'b1, 1'b1, 2'd1, 4'h7, 4'hF);
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_vc_data", 32'({d3, d2, d1, d0}), 32'h0);
        chk("rst_errs", 32'({overflow_err, underflow_err}), 32'h0);

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, 1'b1, tbl[i].push, tbl[i].vc, tbl[i].data, tbl[i].pop);
            chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].exp_empty));
            chk($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_af", i), 32'(almost_full), 32'(tbl[i].exp_af));
            chk($sformatf("tbl%0d_d2", i), 32'(d2), 32'(tbl[i].exp_d2));
            chk($sformatf("tbl%0d_udf", i), 32'(underflow_err), 32'(tbl[i].exp_udf));
        end

        // Overflow: VC0 full, extra push dropped.
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 2'd0, 4'(5 + i), 4'h0);
        step(1'b0, 1'b1, 1'b1, 2'd0, 4'hF, 4'h0);
        chk("ovf_flag", 32'(overflow_err), 32'h1);
        chk("ovf_head", 32'(d0), 32'h5);
        chk("ovf_full", 32'(full[0]), 32'h1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'b0001);
        chk("ovf_drained", 32'(empty[0]), 32'h1);

        // Full VC1 with simultaneous push and pop.
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 2'd1, 4'(10 + i), 4'h0);
        step(1'b0, 1'b1, 1'b1, 2'd1, 4'hE, 4'b0010);
        chk("fpp_head", 32'(d1), 32'hB);
        chk("fpp_full", 32'(full[1]), 32'h1);
        chk("fpp_ovf", 32'(overflow_err), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fpp_pop%0d", i), 32'(d1), 32'(11 + i));
            step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'b0010);
        end

        // Simultaneous push and pop on an empty VC.
        step(1'b0, 1'b1, 1'b1, 2'd2, 4'h9, 4'b0100);
        chk("epp_head", 32'(d2), 32'h9);
        chk("epp_udf", 32'(underflow_err), 32'h1);

        // Hold with enb=0.
        rand_traffic(12);
        s_empty = empty; s_full = full; s_af = almost_full; s_ae = almost_empty;
        s_ovf = overflow_err; s_udf = underflow_err;
        for (int n = 0; n < 4; n++) s_d[n] = dout[n];
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b0, 1'($urandom_range(1)), 2'($urandom_range(3)),
                 4'($urandom_range(15)), 4'($urandom_range(15)));
        chk("hold_flags", 32'({empty, full, almost_full, almost_empty}),
            32'({s_empty, s_full, s_af, s_ae}));
        chk("hold_errs", 32'({overflow_err, underflow_err}), 32'({s_ovf, s_udf}));
        chk("hold_heads", 32'({d3, d2, d1, d0}), 32'({s_d[3], s_d[2], s_d[1], s_d[0]}));
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'hF);

        // Wrap-around on VC3.
        step(1'b1, 1'b1, 1'b0, 2'd0, 4'h0, 4'h0);
        for (int i = 0; i < 3 * DEPTH; i++)
            step(1'b0, 1'b1, 1'b1, 2'd3, 4'(i + 1), (i >= 2) ? 4'b1000 : 4'b0000);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'b1000);
        step(1'b0, 1'b1, 1'b0, 2'd0, 4'h0, 4'b1000);
        chk("wrap_empty", 32'(empty[3]), 32'h1);
        chk("wrap_errs", 32'({overflow_err, underflow_err}), 32'h0);

        rand_traffic(300);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
